// File: rtl/ifetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_queue_if
// Bundle path from instruction memory into the fetch queue, and from the queue
// out to VLIW decode.
//   master : the surrounding pipeline (drives fetch bundles, flush, dec_ready)
//   slave  : ifetch_queue (drives the decode head, fetch_stall, status)
// Signals:
//   if_inst/if_pc/if_valid : fetched bundle, its PC, and its valid flag
//   flush                  : redirect; the bundle on if_inst is wrong-path
//   dec_ready              : decode takes the head entry this cycle
//   dec_inst/dec_pc/dec_valid : head entry presented to decode
//   fetch_stall            : hold the fetch/PC stage
//   occupancy              : number of valid entries
//   ovf_err                : sticky overflow flag
//   dec_slot_valid         : per-slot non-zero mask of dec_inst (only when
//                            IFETCH_QUEUE_NOP_SQUASH_EN is defined)
// ----------------------------------------------------------------------------
interface ifetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 14,
  parameter int INST_W = 128
);
  logic [INST_W-1:0]          if_inst;
  logic [PC_W-1:0]            if_pc;
  logic                       if_valid;
  logic                       flush;
  logic                       dec_ready;
  logic [INST_W-1:0]          dec_inst;
  logic [PC_W-1:0]            dec_pc;
  logic                       dec_valid;
  logic                       fetch_stall;
  logic [$clog2(DEPTH):0]     occupancy;
  logic                       ovf_err;
`ifdef IFETCH_QUEUE_NOP_SQUASH_EN
  logic [3:0]                 dec_slot_valid;
`endif

  modport master (
    output if_inst, if_pc, if_valid, flush, dec_ready,
    input  dec_inst, dec_pc, dec_valid, fetch_stall, occupancy, ovf_err
`ifdef IFETCH_QUEUE_NOP_SQUASH_EN
    , input dec_slot_valid
`endif
  );

  modport slave (
    input  if_inst, if_pc, if_valid, flush, dec_ready,
    output dec_inst, dec_pc, dec_valid, fetch_stall, occupancy, ovf_err
`ifdef IFETCH_QUEUE_NOP_SQUASH_EN
    , output dec_slot_valid
`endif
  );
endinterface

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Circular FIFO of {pc, bundle} entries sitting between the 1-cycle-latency
// instruction memory and VLIW decode. Entries leave in order under a
// valid/ready handshake; flush discards everything including the bundle
// arriving in the flush cycle.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ifetch_queue_if.slave (fetch input, decode output, status)
// Optional feature macro: IFETCH_QUEUE_NOP_SQUASH_EN
//   drops all-zero bundles at the input and adds dec_slot_valid.
// ----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 14,
  parameter int INST_W = 128
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_W = INST_W / 4;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // NOTE: storage has no reset; the pointers and occupancy alone define which
  // entries are meaningful, so clearing the array would only cost area.
  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  logic full, is_nop, push, pop;
  entry_t head;

`ifdef IFETCH_QUEUE_NOP_SQUASH_EN
  assign is_nop = (bus.if_inst == '0);
`else
  assign is_nop = 1'b0;
`endif

  // Full is judged on the pre-pop occupancy: a push colliding with a pop at
  // full is refused, which fetch_stall makes unreachable in legal operation.
  assign full = (occ_q == FULL_CNT);
  assign push = bus.if_valid & ~bus.flush & ~full & ~is_nop;
  assign pop  = (occ_q != '0) & bus.dec_ready & ~bus.flush;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
      if (bus.if_valid & full & ~is_nop) ovf_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // push already excludes flush; rst must also block the write so that an
  // in-flight bundle in the reset cycle never lands in the array.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= '{pc: bus.if_pc, inst: bus.if_inst};
  end

  assign head = mem_q[rd_ptr_q];

  // Head is gated by dec_valid so outputs read zero while empty (and after
  // reset) instead of exposing stale or uninitialised storage.
  assign bus.dec_valid   = (occ_q != '0);
  assign bus.dec_inst    = bus.dec_valid ? head.inst : '0;
  assign bus.dec_pc      = bus.dec_valid ? head.pc   : '0;
  assign bus.occupancy   = occ_q;
  assign bus.ovf_err     = ovf_q;
  // One slot stays free for the bundle already in the memory output register.
  assign bus.fetch_stall = (occ_q >= STALL_CNT);

`ifdef IFETCH_QUEUE_NOP_SQUASH_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.dec_slot_valid[i] = |bus.dec_inst[i*SLOT_W +: SLOT_W];
    end
  end
`endif
endmodule
